// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-based stall, bubble, flush and forwarding control for the in-order pipeline
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_rs1,
  input  logic                       id_rs1_used,
  input  logic [REG_AW-1:0]          id_rs2,
  input  logic                       id_rs2_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_rd_wr_en,
  input  logic                       id_is_load,
  input  logic                       ex_branch_taken,
  output logic                       stall,
  output logic                       bubble_e,
  output logic                       flush_d,
  output logic [$clog2(DEPTH)-1:0]   fwd_rs1_sel,
  output logic [$clog2(DEPTH)-1:0]   fwd_rs2_sel,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);
  localparam int SW = $clog2(DEPTH);

  logic [DEPTH-1:0]             v_q, v_d, wr_q, wr_d, ld_q, ld_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0]            rs1_q, rs1_d, rs2_q, rs2_d;
  logic                         rs1_used_q, rs1_used_d, rs2_used_q, rs2_used_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                         hazard;

  function automatic logic hit(input logic [REG_AW-1:0] s, input logic u, input logic v,
                               input logic w, input logic [REG_AW-1:0] d);
    return u && v && w && (s == d) && (s != '0);
  endfunction

  // decode source against every in-flight producer; loads only stall until they reach the load-data stage
  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < DEPTH; j++)
      if ((hit(id_rs1, id_rs1_used, v_q[j], wr_q[j], rd_q[j]) ||
           hit(id_rs2, id_rs2_used, v_q[j], wr_q[j], rd_q[j])) &&
          (FWD_EN == 0 || (ld_q[j] && j < DEPTH - 2)))
        hazard = 1'b1;
  end

  assign flush_d   = ex_branch_taken;
  assign stall     = id_valid && hazard && !ex_branch_taken;
  assign bubble_e  = stall || ex_branch_taken;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // forward selects: scan oldest to youngest so the youngest matching producer wins
  always_comb begin
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (FWD_EN != 0 && v_q[0] && hit(rs1_q, rs1_used_q, v_q[j], wr_q[j], rd_q[j]))
        fwd_rs1_sel = (ld_q[j] && j < DEPTH - 1) ? '0 : SW'(j);
      if (FWD_EN != 0 && v_q[0] && hit(rs2_q, rs2_used_q, v_q[j], wr_q[j], rd_q[j]))
        fwd_rs2_sel = (ld_q[j] && j < DEPTH - 1) ? '0 : SW'(j);
    end
  end

  // scoreboard shifts every cycle; EX entry takes decode, killed by stall or flush
  always_comb begin
    v_d         = {v_q[DEPTH-2:0], id_valid && !stall && !flush_d};
    wr_d        = {wr_q[DEPTH-2:0], id_rd_wr_en && (id_rd != '0)};
    ld_d        = {ld_q[DEPTH-2:0], id_is_load};
    rd_d        = {rd_q[DEPTH-2:0], id_rd};
    rs1_d       = id_rs1;
    rs2_d       = id_rs2;
    rs1_used_d  = id_rs1_used;
    rs2_used_d  = id_rs2_used;
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_d && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_used_q  <= 1'b0;
      rs2_used_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_used_q  <= rs1_used_d;
      rs2_used_q  <= rs2_used_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench comparing forwarding and non-forwarding instances against an instruction-level model
module tb_hazard_unit;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, u1 = 0, u2 = 0, we = 0, ld = 0, br = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic st0, bu0, fl0, st1, bu1, fl1;
  logic [1:0] a0, b0, a1, b1;
  logic [31:0] sc0, fc0;
  logic [2:0] sc1, fc1;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.REG_AW(5), .DEPTH(D), .FWD_EN(1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(rs1), .id_rs1_used(u1),
    .id_rs2(rs2), .id_rs2_used(u2), .id_rd(rd), .id_rd_wr_en(we), .id_is_load(ld),
    .ex_branch_taken(br), .stall(st0), .bubble_e(bu0), .flush_d(fl0),
    .fwd_rs1_sel(a0), .fwd_rs2_sel(b0), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_unit #(.REG_AW(5), .DEPTH(D), .FWD_EN(0), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(rs1), .id_rs1_used(u1),
    .id_rs2(rs2), .id_rs2_used(u2), .id_rd(rd), .id_rd_wr_en(we), .id_is_load(ld),
    .ex_branch_taken(br), .stall(st1), .bubble_e(bu1), .flush_d(fl1),
    .fwd_rs1_sel(a1), .fwd_rs2_sel(b1), .stall_cnt(sc1), .flush_cnt(fc1));

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rd; bit we; bit ld; int r1; int r2; bit u1; bit u2;
  } ins_t;

  typedef struct {
    bit st; bit bu; bit fl; int s1; int s2; longint sc; longint fc;
  } exp_t;

  ins_t   pipe[2][D];
  longint scnt[2], fcnt[2];
  exp_t   q0[$], q1[$];

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < D; j++) pipe[k][j] = '{0, 0, 0, 0, 0, 0, 0, 0};
      scnt[k] = 0;
      fcnt[k] = 0;
    end
  endtask

  // producer p at stage j, source s: does it hold the value s needs
  function automatic bit produces(ins_t p, int s, bit u);
    return u && s != 0 && p.v && p.we && p.rd == s;
  endfunction

  // consumer would enter EX next cycle; producer then sits one stage further on
  function automatic bit must_wait(int k, int s, bit u);
    bit w = 0;
    for (int j = 0; j < D; j++)
      if (produces(pipe[k][j], s, u))
        if (k == 1 || (pipe[k][j].ld && j + 1 < D - 1)) w = 1;
    return w;
  endfunction

  function automatic int pick(int k, int s, bit u);
    if (k == 1 || !pipe[k][0].v) return 0;
    for (int j = 1; j < D; j++)
      if (produces(pipe[k][j], s, u)) return (pipe[k][j].ld && j < D - 1) ? 0 : j;
    return 0;
  endfunction

  task automatic step(input bit iv, input int r1, input bit x1, input int r2, input bit x2,
                      input int d, input bit w, input bit l, input bit b);
    exp_t e;
    longint cmax;
    @(posedge clk);
    #1;
    id_valid = iv; rs1 = 5'(r1); u1 = x1; rs2 = 5'(r2); u2 = x2;
    rd = 5'(d); we = w; ld = l; br = b;
    for (int k = 0; k < 2; k++) begin
      cmax = (k == 1) ? 64'd7 : 64'hFFFF_FFFF;
      e.st = iv && !b && (must_wait(k, r1, x1) || must_wait(k, r2, x2));
      e.fl = b;
      e.bu = e.st || b;
      e.s1 = pick(k, pipe[k][0].r1, pipe[k][0].u1);
      e.s2 = pick(k, pipe[k][0].r2, pipe[k][0].u2);
      e.sc = scnt[k];
      e.fc = fcnt[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      if (e.st && scnt[k] < cmax) scnt[k]++;
      if (b && fcnt[k] < cmax) fcnt[k]++;
      for (int j = D - 1; j > 0; j--) pipe[k][j] = pipe[k][j-1];
      pipe[k][0] = '{iv && !e.st && !b, d, w && d != 0, l, r1, r2, x1, x2};
    end
  endtask

  // monitor: pops one expected response per instance each cycle
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("fwd.stall", st0, e.st);   chk("fwd.bubble_e", bu0, e.bu);
      chk("fwd.flush_d", fl0, e.fl); chk("fwd.sel1", a0, e.s1);
      chk("fwd.sel2", b0, e.s2);     chk("fwd.stall_cnt", sc0, e.sc);
      chk("fwd.flush_cnt", fc0, e.fc);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("nofwd.stall", st1, e.st);   chk("nofwd.bubble_e", bu1, e.bu);
      chk("nofwd.flush_d", fl1, e.fl); chk("nofwd.sel1", a1, e.s1);
      chk("nofwd.sel2", b1, e.s2);     chk("nofwd.stall_cnt", sc1, e.sc);
      chk("nofwd.flush_cnt", fc1, e.fc);
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    id_valid = 0; br = 0; u1 = 0; u2 = 0; we = 0; ld = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #3;
    chk("reset.stall", st0, 0); chk("reset.bubble", bu0, 0); chk("reset.flush", fl0, 0);
    chk("reset.sel1", a0, 0);   chk("reset.sc", sc0, 0);     chk("reset.fc", fc0, 0);
    @(posedge clk);
    #1;
    rst = 0;

    // load-use: lw x7 ; add x8,x7,x1
    step(1, 0, 1, 0, 0, 7, 1, 1, 0);
    step(1, 7, 1, 1, 1, 8, 1, 0, 0);
    settle(); chk("lu.stall", st0, 1); chk("lu.bubble", bu0, 1);
    step(1, 7, 1, 1, 1, 8, 1, 0, 0);
    settle(); chk("lu.stall_released", st0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("lu.sel1", a0, 2); chk("lu.sel2", b0, 0); chk("lu.stall_cnt", sc0, 1);

    // reset asserted in the middle of a load-use stall
    step(1, 0, 1, 0, 0, 7, 1, 1, 0);
    step(1, 7, 1, 1, 1, 8, 1, 0, 0);
    settle(); chk("mid.stall_before", st0, 1);
    rst = 1;
    #1;
    chk("mid.stall", st0, 0); chk("mid.bubble", bu0, 0); chk("mid.sel1", a0, 0);
    chk("mid.stall_cnt", sc0, 0); chk("nofwd.mid.stall", st1, 0);
    id_valid = 0; u1 = 0; u2 = 0; we = 0; ld = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    settle(); chk("post.stall_cnt", sc0, 0); chk("post.flush_cnt", fc0, 0);

    // no-forwarding instance: add x3 ; sub x4,x3,x2 stalls for EX, MEM and WB
    step(1, 1, 1, 2, 1, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 3, 1, 2, 1, 4, 1, 0, 0);
    settle(); chk("nofwd.stall_cnt3", sc1, 3); chk("nofwd.sel1", a1, 0);

    // back-to-back ALU: add x5 ; add x6,x5,x5 ; add x7,x5,x0
    do_reset();
    step(1, 1, 1, 2, 1, 5, 1, 0, 0);
    step(1, 5, 1, 5, 1, 6, 1, 0, 0);
    settle(); chk("b2b.stall", st0, 0);
    step(1, 5, 1, 0, 1, 7, 1, 0, 0);
    settle(); chk("b2b.sel1", a0, 1); chk("b2b.sel2", b0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("b2b.sel_older", a0, 2);

    // x0 writer then x0 reader; then two writers of x9
    step(1, 1, 1, 1, 1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1, 10, 1, 0, 0);
    settle(); chk("x0.stall", st0, 0);
    step(1, 1, 1, 1, 1, 9, 1, 0, 0);
    settle(); chk("x0.sel1", a0, 0);
    step(1, 1, 1, 1, 1, 9, 1, 0, 0);
    step(1, 9, 1, 0, 0, 11, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("youngest.sel1", a0, 1);

    // branch taken while decode holds a load-use consumer
    step(1, 0, 1, 0, 0, 12, 1, 1, 0);
    step(1, 12, 1, 0, 0, 13, 1, 0, 1);
    settle(); chk("br.flush", fl0, 1); chk("br.bubble", bu0, 1); chk("br.stall", st0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("br.flush_cnt", fc0, 1); chk("br.killed_sel", a0, 0);

    // randomized traffic over a small register pool to provoke hazards
    for (int i = 0; i < 3000; i++)
      step($urandom_range(7, 0) != 0, $urandom_range(3, 0), $urandom_range(1, 0),
           $urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(3, 0),
           $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0, $urandom_range(7, 0) == 0);
    settle();
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
